// File: rtl/xor_mask_pipe.sv
// xor_mask_pipe: each accepted word is XORed with a programmable mask and
// stored in a small FIFO. The FIFO drains through a valid/ready output port,
// and a wrapping counter tracks the completed output transfers.
//
// Handshake: a transfer happens on a rising edge where valid && ready.
// - in_ready depends only on occupancy (occ < DEPTH). It never looks at
//   out_ready, so a full FIFO refuses a push even on an edge where it pops.
// - out_valid is high whenever the FIFO holds a word, and out_data is the
//   head entry. With the FIFO empty, out_data is zero and out_ready is ignored.
module xor_mask_pipe #(
    parameter int             N         = 4,
    parameter logic [N-1:0]   MASK_INIT = 4'b0101,
    parameter int             DEPTH     = 2,
    parameter int             CW        = 8
) (
    input  logic          clk,
    input  logic          reset,
    input  logic          in_valid,
    output logic          in_ready,
    input  logic [N-1:0]  in_data,
    input  logic          mask_wr,
    input  logic [N-1:0]  mask_data,
    output logic          out_valid,
    input  logic          out_ready,
    output logic [N-1:0]  out_data,
    output logic [CW-1:0] count
);

    // The pointer width is log2(DEPTH). Occupancy has one extra bit so it can
    // hold the value DEPTH.
    localparam int             AW      = $clog2(DEPTH);
    localparam logic [AW:0]    DEPTH_O = DEPTH[AW:0];
    localparam logic [AW:0]    ONE_O   = 1;
    localparam logic [AW-1:0]  ONE_P   = 1;
    localparam logic [CW-1:0]  ONE_C   = 1;

    logic [N-1:0]  mask_q, mask_d;
    logic [AW:0]   occ_q, occ_d;
    logic [AW-1:0] head_q, head_d;
    logic [AW-1:0] tail_q, tail_d;
    logic [CW-1:0] count_q, count_d;
    logic [N-1:0]  mem_q [DEPTH];
    logic [N-1:0]  mem_d [DEPTH];

    logic push;
    logic pop;

    // Handshake decode. A push is possible only while there is room, and a pop
    // only while a word is present.
    always_comb begin
        in_ready  = (occ_q < DEPTH_O);
        out_valid = (occ_q != '0);
        out_data  = out_valid ? mem_q[head_q] : '0;
        count     = count_q;
        push      = in_valid && in_ready;
        pop       = out_valid && out_ready;
    end

    // Next-state logic for the mask, pointers, occupancy and transfer counter.
    // The stored word uses the mask value from before the edge, so a mask
    // write on the same edge only affects later words.
    always_comb begin
        mask_d  = mask_wr ? mask_data : mask_q;
        head_d  = pop  ? head_q + ONE_P : head_q;
        tail_d  = push ? tail_q + ONE_P : tail_q;
        count_d = pop  ? count_q + ONE_C : count_q;
        occ_d   = occ_q;
        case ({push, pop})
            2'b10:   occ_d = occ_q + ONE_O;
            2'b01:   occ_d = occ_q - ONE_O;
            default: occ_d = occ_q;
        endcase
        for (int i = 0; i < DEPTH; i++) begin
            mem_d[i] = mem_q[i];
        end
        if (push) begin
            mem_d[tail_q] = in_data ^ mask_q;
        end
    end

    // Control state register. Reset takes priority over mask writes and
    // transfers, and dropping occupancy to zero discards any buffered words.
    always_ff @(posedge clk) begin
        if (reset) begin
            mask_q  <= MASK_INIT;
            occ_q   <= '0;
            head_q  <= '0;
            tail_q  <= '0;
            count_q <= '0;
        end else begin
            mask_q  <= mask_d;
            occ_q   <= occ_d;
            head_q  <= head_d;
            tail_q  <= tail_d;
            count_q <= count_d;
        end
    end

    // FIFO storage. It needs no reset because out_data is forced to zero
    // while the FIFO is empty.
    always_ff @(posedge clk) begin
        for (int i = 0; i < DEPTH; i++) begin
            mem_q[i] <= mem_d[i];
        end
    end

endmodule

// File: tb/tb_xor_mask_pipe.sv
// Directed bench for xor_mask_pipe. dut uses the default parameters. dut_w
// (CW=3) receives the same inputs and is used to observe the counter wrap.
module tb_xor_mask_pipe;

    logic       clk = 1'b0;
    logic       reset;
    logic       in_valid;
    logic [3:0] in_data;
    logic       mask_wr;
    logic [3:0] mask_data;
    logic       out_ready;

    logic       in_ready,  out_valid;
    logic [3:0] out_data;
    logic [7:0] count;
    logic       in_ready_w, out_valid_w;
    logic [3:0] out_data_w;
    logic [2:0] count_w;

    int errors = 0;
    int checks = 0;

    // ---------------- clock / reset ----------------
    always #5 clk = ~clk;

    xor_mask_pipe dut (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready),
        .in_data(in_data), .mask_wr(mask_wr), .mask_data(mask_data),
        .out_valid(out_valid), .out_ready(out_ready), .out_data(out_data),
        .count(count)
    );

    xor_mask_pipe #(.CW(3)) dut_w (
        .clk(clk), .reset(reset), .in_valid(in_valid), .in_ready(in_ready_w),
        .in_data(in_data), .mask_wr(mask_wr), .mask_data(mask_data),
        .out_valid(out_valid_w), .out_ready(out_ready), .out_data(out_data_w),
        .count(count_w)
    );

    // ---------------- driver tasks ----------------
    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic drive(input logic iv, input logic [3:0] d, input logic ordy,
                         input logic mw, input logic [3:0] md);
        in_valid  = iv;
        in_data   = d;
        out_ready = ordy;
        mask_wr   = mw;
        mask_data = md;
    endtask

    task automatic chk(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", name, act, exp);
        end
    endtask

    task automatic chk_state(input string tag, input logic e_ir, input logic e_ov,
                             input logic [3:0] e_od, input logic [7:0] e_cnt);
        chk({tag, " in_ready"},  32'(in_ready),  32'(e_ir));
        chk({tag, " out_valid"}, 32'(out_valid), 32'(e_ov));
        chk({tag, " out_data"},  32'(out_data),  32'(e_od));
        chk({tag, " count"},     32'(count),     32'(e_cnt));
    endtask

    // ---------------- vector table ----------------
    // Each record lists the inputs applied for one cycle and the outputs
    // expected in that cycle, before the rising edge that ends it.
    typedef struct {
        logic       iv;
        logic [3:0] d;
        logic       ordy;
        logic       mw;
        logic [3:0] md;
        logic       e_ir;
        logic       e_ov;
        logic [3:0] e_od;
        logic [7:0] e_cnt;
    } vec_t;

    vec_t vecs[19];

    initial begin
        // basic stream with mask 0101
        vecs[0]  = '{1'b1, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'b0000, 8'd0};
        vecs[1]  = '{1'b1, 4'h1, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0101, 8'd0};
        vecs[2]  = '{1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0100, 8'd1};
        vecs[3]  = '{1'b1, 4'h3, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0111, 8'd2};
        vecs[4]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0110, 8'd3};
        vecs[5]  = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'b0000, 8'd4};
        // backpressure: the third word waits while the FIFO is full
        vecs[6]  = '{1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b0, 4'b0000, 8'd4};
        vecs[7]  = '{1'b1, 4'h1, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0101, 8'd4};
        vecs[8]  = '{1'b1, 4'h2, 1'b0, 1'b0, 4'h0, 1'b0, 1'b1, 4'b0101, 8'd4};
        vecs[9]  = '{1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'b0101, 8'd4};
        vecs[10] = '{1'b1, 4'h2, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0100, 8'd5};
        vecs[11] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0111, 8'd6};
        vecs[12] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'b0000, 8'd7};
        // mask write on the same edge as a push: that push uses the old mask
        vecs[13] = '{1'b1, 4'h0, 1'b0, 1'b1, 4'hF, 1'b1, 1'b0, 4'b0000, 8'd7};
        vecs[14] = '{1'b1, 4'h0, 1'b0, 1'b0, 4'h0, 1'b1, 1'b1, 4'b0101, 8'd7};
        vecs[15] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b0, 1'b1, 4'b0101, 8'd7};
        vecs[16] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b1, 4'b1111, 8'd8};
        // empty: out_ready is ignored and the count holds
        vecs[17] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'b0000, 8'd9};
        vecs[18] = '{1'b0, 4'h0, 1'b1, 1'b0, 4'h0, 1'b1, 1'b0, 4'b0000, 8'd9};
    end

    // ---------------- test sequence ----------------
    initial begin
        drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        reset = 1'b1;
        @(negedge clk);
        tick();
        reset = 1'b0;
        chk_state("reset", 1'b1, 1'b0, 4'h0, 8'd0);
        chk("reset count_w", 32'(count_w), 32'd0);

        for (int i = 0; i < 19; i++) begin
            drive(vecs[i].iv, vecs[i].d, vecs[i].ordy, vecs[i].mw, vecs[i].md);
            #1;
            chk_state($sformatf("vec%0d", i), vecs[i].e_ir, vecs[i].e_ov,
                      vecs[i].e_od, vecs[i].e_cnt);
            chk($sformatf("vec%0d count_w", i), 32'(count_w), 32'(vecs[i].e_cnt[2:0]));
            chk($sformatf("vec%0d out_data_w", i), 32'(out_data_w), 32'(vecs[i].e_od));
            chk($sformatf("vec%0d in_ready_w", i), 32'(in_ready_w), 32'(vecs[i].e_ir));
            chk($sformatf("vec%0d out_valid_w", i), 32'(out_valid_w), 32'(vecs[i].e_ov));
            tick();
        end

        // Reset in the middle of a stream. The mask is 1111 and two words are
        // buffered. A mask write on the reset edge must lose to reset.
        drive(1'b1, 4'h0, 1'b0, 1'b0, 4'h0);
        tick();
        drive(1'b1, 4'h1, 1'b0, 1'b0, 4'h0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        #1;
        chk_state("full before reset", 1'b0, 1'b1, 4'b1111, 8'd9);
        reset = 1'b1;
        drive(1'b1, 4'h3, 1'b1, 1'b1, 4'b1010);
        tick();
        reset = 1'b0;
        drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        #1;
        chk_state("after mid reset", 1'b1, 1'b0, 4'h0, 8'd0);
        chk("after mid reset count_w", 32'(count_w), 32'd0);
        drive(1'b1, 4'h0, 1'b0, 1'b0, 4'h0);
        tick();
        drive(1'b0, 4'h0, 1'b0, 1'b0, 4'h0);
        #1;
        chk_state("post reset word", 1'b1, 1'b1, 4'b0101, 8'd0);
        drive(1'b0, 4'h0, 1'b1, 1'b0, 4'h0);
        tick();
        #1;
        chk_state("post reset drained", 1'b1, 1'b0, 4'h0, 8'd1);

        // Counter wrap on the CW=3 instance. Streaming with out_ready high
        // pops once per cycle from the second cycle on, so the observed counts
        // are 0,0,1..7,0,1 across nine output transfers.
        reset = 1'b1;
        tick();
        reset = 1'b0;
        for (int c = 0; c <= 10; c++) begin
            drive(1'b1, 4'(c), 1'b1, 1'b0, 4'h0);
            #1;
            chk($sformatf("wrap c%0d count_w", c), 32'(count_w),
                32'(((c == 0) ? 0 : c - 1) % 8));
            chk($sformatf("wrap c%0d count", c), 32'(count),
                32'((c == 0) ? 0 : c - 1));
            if (c > 0) begin
                chk($sformatf("wrap c%0d out_data", c), 32'(out_data),
                    32'(4'(c - 1) ^ 4'b0101));
                chk($sformatf("wrap c%0d in_ready", c), 32'(in_ready), 32'd1);
            end
            tick();
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
